// File: rtl/dsp_sched_pkg.sv
// ---------------------------------------------------------------------------
// dsp_sched_pkg
// Shared types and constants for the DSP instruction scheduler.
//   - sched_state_t : scheduler FSM states
//   - INST_W        : width of an instruction word without the execute bit
//   - EXEC_BIT      : position of the execute bit on the controller bus
//   - *_LSB/*_MSB   : field positions inside an instruction word
//   - make_inst()   : packs the individual fields into one instruction word
// ---------------------------------------------------------------------------
package dsp_sched_pkg;

    localparam int INST_W   = 31;
    localparam int EXEC_BIT = 31;

    localparam int BRAM0_RADDR_LSB = 0;
    localparam int BRAM0_RADDR_MSB = 4;
    localparam int BRAM1_RADDR_LSB = 5;
    localparam int BRAM1_RADDR_MSB = 9;
    localparam int BRAM1_WADDR_LSB = 10;
    localparam int BRAM1_WADDR_MSB = 14;
    localparam int INMODE_LSB      = 15;
    localparam int INMODE_MSB      = 19;
    localparam int OPMODE_LSB      = 20;
    localparam int OPMODE_MSB      = 26;
    localparam int ALUMODE_LSB     = 27;
    localparam int ALUMODE_MSB     = 30;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        GAP  = 2'd2
    } sched_state_t;

    function automatic logic [INST_W-1:0] make_inst(
        input logic [3:0] alumode,
        input logic [6:0] opmode,
        input logic [4:0] inmode,
        input logic [4:0] bram1_waddr,
        input logic [4:0] bram1_raddr,
        input logic [4:0] bram0_raddr
    );
        logic [INST_W-1:0] w;
        w = '0;
        w[ALUMODE_MSB:ALUMODE_LSB]         = alumode;
        w[OPMODE_MSB:OPMODE_LSB]           = opmode;
        w[INMODE_MSB:INMODE_LSB]           = inmode;
        w[BRAM1_WADDR_MSB:BRAM1_WADDR_LSB] = bram1_waddr;
        w[BRAM1_RADDR_MSB:BRAM1_RADDR_LSB] = bram1_raddr;
        w[BRAM0_RADDR_MSB:BRAM0_RADDR_LSB] = bram0_raddr;
        return w;
    endfunction

endpackage

// File: rtl/dsp_sched_fifo.sv
// ---------------------------------------------------------------------------
// dsp_sched_fifo
// Synchronous instruction FIFO with push, pop, flush and an exact occupancy
// count.
//   clk      in   clock
//   reset    in   synchronous reset, active-low
//   i_push   in   write request (accepted unless full, or full with a pop)
//   i_pop    in   read request (ignored when empty)
//   i_flush  in   empty the FIFO; overrides push and pop
//   i_wdata  in   word to write
//   o_rdata  out  head word (combinational read of the head entry)
//   o_count  out  number of stored entries, 0..DEPTH
//   o_full   out  o_count == DEPTH
//   o_empty  out  o_count == 0
// ---------------------------------------------------------------------------
module dsp_sched_fifo
    import dsp_sched_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = INST_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_full;
    logic w_empty;
    logic w_pop_ok;
    logic w_push_ok;

    assign w_full   = (r_count == (AW+1)'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_pop_ok = i_pop && !w_empty && !i_flush;
    // A full FIFO still takes a word when the head leaves in the same cycle.
    assign w_push_ok = i_push && !i_flush && (!w_full || w_pop_ok);

    // Pointers are AW bits wide, so they wrap mod DEPTH on their own.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = w_full;
    assign o_empty = w_empty;

endmodule

// File: rtl/dsp_inst_scheduler.sv
// ---------------------------------------------------------------------------
// dsp_inst_scheduler
// Queues 31-bit BRAM/DSP instruction words from a host and issues them one
// at a time to the BRAM/DSP controller. The execute bit inst[31] is held high
// for EXEC_CYCLES, then low for GAP_CYCLES so the controller's step counter
// rearms before the next instruction.
//
// Handshake: a host word is taken on a rising clk edge when in_valid and
// in_ready are both high (in_ready = FIFO not full). One extra case: a word
// offered while the FIFO is full is still taken if the head is popped on the
// same edge. flush discards any word offered in that cycle.
//
// Ports:
//   clk          in   clock
//   reset        in   synchronous reset, active-low
//   in_valid     in   host instruction valid
//   in_ready     out  FIFO not full
//   in_inst      in   {alumode,opmode,inmode,bram1_waddr,bram1_raddr,bram0_raddr}
//   run          in   1 = issue from FIFO, 0 = hold in IDLE after current inst
//   flush        in   drop queued entries and abort the current instruction
//   inst         out  {execute, fields} to the controller (registered)
//   busy         out  FSM not in IDLE (registered)
//   done         out  1-cycle pulse on the last GAP cycle of a completed inst
//   fifo_count   out  queued entries
//   o_dbg_state  out  current FSM state (sched_state_t encoding)
//   retired_cnt  out  instructions completed     (DSP_SCHED_PERF_EN only)
//   busy_cnt     out  cycles with busy high      (DSP_SCHED_PERF_EN only)
//
// Build option: define DSP_SCHED_PERF_EN to add the two 32-bit performance
// counters. They wrap, clear on reset and are not affected by flush.
// ---------------------------------------------------------------------------
module dsp_inst_scheduler
    import dsp_sched_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int EXEC_CYCLES = 6,
    parameter int GAP_CYCLES  = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INST_W-1:0]      in_inst,
    input  logic                   run,
    input  logic                   flush,
    output logic [INST_W:0]        inst,
    output logic                   busy,
    output logic                   done,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic [1:0]             o_dbg_state
`ifdef DSP_SCHED_PERF_EN
    ,
    output logic [31:0]            retired_cnt,
    output logic [31:0]            busy_cnt
`endif
);

    localparam int CNT_MAX = (EXEC_CYCLES > GAP_CYCLES) ? EXEC_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] EXEC_LAST = CNT_W'(EXEC_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    // GAP count one before the last GAP cycle; only meaningful for GAP_CYCLES > 1.
    localparam logic [CNT_W-1:0] GAP_PRE   = CNT_W'((GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0);

    sched_state_t        r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [INST_W-1:0]   r_cur;
    logic [INST_W:0]     r_inst;
    logic                r_busy;
    logic                r_done;
    // Set while the GAP following a flushed instruction is running, so that
    // GAP does not report completion for it.
    logic                r_abort;

    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [INST_W-1:0]   w_head;
    logic                w_pop_slot;
    logic                w_pop;

    // The FIFO can only be popped from IDLE or from the last GAP cycle.
    assign w_pop_slot = (r_state == IDLE) || ((r_state == GAP) && (r_cnt == GAP_LAST));
    assign w_pop      = w_pop_slot && run && !flush && !w_fifo_empty;

    dsp_sched_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INST_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (in_valid),
        .i_pop   (w_pop),
        .i_flush (flush),
        .i_wdata (in_inst),
        .o_rdata (w_head),
        .o_count (fifo_count),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_cur   <= '0;
            r_inst  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_cur   <= w_head;
                        r_cnt   <= '0;
                        r_inst  <= {1'b1, w_head};
                        r_busy  <= 1'b1;
                        r_abort <= 1'b0;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    if (flush) begin
                        // Abort: execute falls next cycle, the gap still runs
                        // so the controller rearms, but no done is produced.
                        r_cnt            <= '0;
                        r_inst[EXEC_BIT] <= 1'b0;
                        r_abort          <= 1'b1;
                        r_state          <= GAP;
                    end else if (r_cnt == EXEC_LAST) begin
                        r_cnt            <= '0;
                        r_inst[EXEC_BIT] <= 1'b0;
                        r_done           <= (GAP_CYCLES == 1);
                        r_state          <= GAP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        if (w_pop) begin
                            r_cur   <= w_head;
                            r_cnt   <= '0;
                            r_inst  <= {1'b1, w_head};
                            r_abort <= 1'b0;
                            r_state <= EXEC;
                        end else begin
                            r_cnt   <= '0;
                            r_busy  <= 1'b0;
                            r_abort <= 1'b0;
                            r_state <= IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if ((GAP_CYCLES > 1) && (r_cnt == GAP_PRE) && !r_abort) begin
                            r_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                    r_inst  <= {1'b0, r_cur};
                end
            endcase
        end
    end

    assign in_ready    = !w_fifo_full;
    assign inst        = r_inst;
    assign busy        = r_busy;
    assign done        = r_done;
    assign o_dbg_state = r_state;

`ifdef DSP_SCHED_PERF_EN
    logic [31:0] r_retired_cnt;
    logic [31:0] r_busy_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_retired_cnt <= '0;
            r_busy_cnt    <= '0;
        end else begin
            if (r_done) begin
                r_retired_cnt <= r_retired_cnt + 32'd1;
            end
            if (r_busy) begin
                r_busy_cnt <= r_busy_cnt + 32'd1;
            end
        end
    end

    assign retired_cnt = r_retired_cnt;
    assign busy_cnt    = r_busy_cnt;
`endif

endmodule

// File: tb/tb_dsp_inst_scheduler.sv
// ---------------------------------------------------------------------------
// tb_dsp_inst_scheduler
// Directed bench for dsp_inst_scheduler (DEPTH=8, EXEC_CYCLES=6,
// GAP_CYCLES=1). Inputs change 1 time unit after the rising edge; outputs are
// observed at the same point, i.e. they show the registers updated by the
// edge just passed. "cycle k" below means k rising edges after the cycle in
// which the stimulus was driven.
// ---------------------------------------------------------------------------
module tb_dsp_inst_scheduler;
    import dsp_sched_pkg::*;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [30:0] in_inst;
    logic        run;
    logic        flush;
    logic [31:0] inst;
    logic        busy;
    logic        done;
    logic [3:0]  fifo_count;
    logic [1:0]  dbg_state;
`ifdef DSP_SCHED_PERF_EN
    logic [31:0] retired_cnt;
    logic [31:0] busy_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [30:0] exp_q[$];

    dsp_inst_scheduler #(
        .DEPTH       (8),
        .EXEC_CYCLES (6),
        .GAP_CYCLES  (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_inst     (in_inst),
        .run         (run),
        .flush       (flush),
        .inst        (inst),
        .busy        (busy),
        .done        (done),
        .fifo_count  (fifo_count),
        .o_dbg_state (dbg_state)
`ifdef DSP_SCHED_PERF_EN
        ,
        .retired_cnt (retired_cnt),
        .busy_cnt    (busy_cnt)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [30:0] word_of(input int i);
        return make_inst(4'(i + 1), 7'(i * 3 + 2), 5'(i + 7), 5'(i * 2), 5'(31 - i), 5'(i + 11));
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        reset    = 1'b0;
        in_valid = 1'b0;
        in_inst  = '0;
        run      = 1'b0;
        flush    = 1'b0;
        tick();
        tick();
        checks++;
        if (inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h want 0", inst); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %b%b want 00", busy, done); end
        checks++;
        if (fifo_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        checks++;
        if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
        reset = 1'b1;
        tick();
    endtask

    // Single word pushed into an empty, idle scheduler with run=1.
    task automatic test_single();
        logic [30:0] w;
        w        = 31'h0000_1021;
        in_valid = 1'b1;
        in_inst  = w;
        run      = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            checks++;
            if (inst[31] !== (k >= 2 && k <= 7)) begin
                errors++; $display("FAIL single_exec c%0d: got %b want %b", k, inst[31], (k >= 2 && k <= 7));
            end
            checks++;
            if (done !== (k == 8)) begin
                errors++; $display("FAIL single_done c%0d: got %b want %b", k, done, (k == 8));
            end
            if (k >= 2) begin
                checks++;
                if (inst[30:0] !== w) begin errors++; $display("FAIL single_fields c%0d: got %h want %h", k, inst[30:0], w); end
            end
            checks++;
            if (busy !== (k >= 2 && k <= 8)) begin
                errors++; $display("FAIL single_busy c%0d: got %b want %b", k, busy, (k >= 2 && k <= 8));
            end
            tick();
        end
        run = 1'b0;
    endtask

    // Three queued words issued back to back.
    task automatic test_back_to_back();
        logic [30:0] w [3];
        int idx;
        for (int i = 0; i < 3; i++) begin
            w[i]     = word_of(i + 20);
            in_valid = 1'b1;
            in_inst  = w[i];
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (fifo_count !== 4'd3) begin errors++; $display("FAIL b2b_count_start: got %0d want 3", fifo_count); end
        run = 1'b1;
        tick();
        for (int k = 1; k <= 22; k++) begin
            idx = (k - 1) / 7;
            checks++;
            if (inst[31] !== ((k <= 21) && ((k - 1) % 7 != 6))) begin
                errors++; $display("FAIL b2b_exec c%0d: got %b", k, inst[31]);
            end
            checks++;
            if (done !== ((k <= 21) && ((k - 1) % 7 == 6))) begin
                errors++; $display("FAIL b2b_done c%0d: got %b", k, done);
            end
            checks++;
            if (inst[30:0] !== w[(idx > 2) ? 2 : idx]) begin
                errors++; $display("FAIL b2b_fields c%0d: got %h want %h", k, inst[30:0], w[(idx > 2) ? 2 : idx]);
            end
            checks++;
            if (fifo_count !== 4'((idx >= 2) ? 0 : 2 - idx)) begin
                errors++; $display("FAIL b2b_count c%0d: got %0d want %0d", k, fifo_count, (idx >= 2) ? 0 : 2 - idx);
            end
            tick();
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: busy got %b want 0", busy); end
        run = 1'b0;
    endtask

    // Overfill with run=0, then drain: only DEPTH words come out.
    task automatic test_overflow();
        int model_count;
        int n_issued;
        int n_done;
        logic prev;
        logic [30:0] e;
        model_count = 0;
        exp_q.delete();
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_inst  = word_of(i);
            if (model_count < 8) begin
                exp_q.push_back(word_of(i));
                model_count++;
            end
            tick();
            checks++;
            if (fifo_count !== 4'(model_count)) begin errors++; $display("FAIL ovf_count p%0d: got %0d want %0d", i, fifo_count, model_count); end
            checks++;
            if (in_ready !== (model_count < 8)) begin errors++; $display("FAIL ovf_ready p%0d: got %b want %b", i, in_ready, (model_count < 8)); end
        end
        in_valid = 1'b0;
        run      = 1'b1;
        prev     = 1'b0;
        n_issued = 0;
        n_done   = 0;
        for (int c = 0; c < 80; c++) begin
            if (inst[31] && !prev) begin
                n_issued++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL ovf_extra: issue %0d with expected queue empty", n_issued);
                end else begin
                    e = exp_q.pop_front();
                    if (inst[30:0] !== e) begin errors++; $display("FAIL ovf_fields i%0d: got %h want %h", n_issued, inst[30:0], e); end
                end
            end
            if (done) n_done++;
            prev = inst[31];
            tick();
        end
        checks++;
        if (n_issued !== 8) begin errors++; $display("FAIL ovf_issued: got %0d want 8", n_issued); end
        checks++;
        if (n_done !== 8) begin errors++; $display("FAIL ovf_done: got %0d want 8", n_done); end
        checks++;
        if (fifo_count !== 4'd0 || busy !== 1'b0) begin errors++; $display("FAIL ovf_end: count %0d busy %b want 0 0", fifo_count, busy); end
        run = 1'b0;
    endtask

    // Full FIFO: a push in the same cycle as a pop is accepted.
    task automatic test_full_push_pop();
        int n_issued;
        logic prev;
        logic [30:0] e;
        exp_q.delete();
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_inst  = word_of(i + 40);
            exp_q.push_back(word_of(i + 40));
            tick();
        end
        checks++;
        if (fifo_count !== 4'd8 || in_ready !== 1'b0) begin errors++; $display("FAIL fpp_full: count %0d ready %b want 8 0", fifo_count, in_ready); end
        in_inst = word_of(60);
        exp_q.push_back(word_of(60));
        run = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (fifo_count !== 4'd8) begin errors++; $display("FAIL fpp_count: got %0d want 8", fifo_count); end
        prev     = 1'b0;
        n_issued = 0;
        for (int c = 0; c < 80; c++) begin
            if (inst[31] && !prev) begin
                n_issued++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL fpp_extra: issue %0d with expected queue empty", n_issued);
                end else begin
                    e = exp_q.pop_front();
                    if (inst[30:0] !== e) begin errors++; $display("FAIL fpp_fields i%0d: got %h want %h", n_issued, inst[30:0], e); end
                end
            end
            prev = inst[31];
            tick();
        end
        checks++;
        if (n_issued !== 9) begin errors++; $display("FAIL fpp_issued: got %0d want 9", n_issued); end
        run = 1'b0;
    endtask

    // Flush in the third EXEC cycle with two words queued and a push offered.
    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_inst  = word_of(i + 70);
            tick();
        end
        in_valid = 1'b0;
        run = 1'b1;
        tick();
        checks++;
        if (inst[31] !== 1'b1 || fifo_count !== 4'd2) begin errors++; $display("FAIL flush_pre: exec %b count %0d want 1 2", inst[31], fifo_count); end
        tick();
        tick();
        flush    = 1'b1;
        in_valid = 1'b1;
        in_inst  = word_of(99);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (inst[31] !== 1'b0) begin errors++; $display("FAIL flush_exec: got %b want 0", inst[31]); end
        checks++;
        if (fifo_count !== 4'd0) begin errors++; $display("FAIL flush_count: got %0d want 0", fifo_count); end
        checks++;
        if (dbg_state !== 2'd2 || busy !== 1'b1) begin errors++; $display("FAIL flush_gap: state %0d busy %b want 2 1", dbg_state, busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL flush_done_gap: got %b want 0", done); end
        tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy_after: got %b want 0", busy); end
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (done !== 1'b0 || inst[31] !== 1'b0) begin errors++; $display("FAIL flush_quiet c%0d: done %b exec %b want 0 0", c, done, inst[31]); end
            tick();
        end
        run = 1'b0;
    endtask

    // Reset asserted in the second EXEC cycle, then a fresh instruction.
    task automatic test_reset_mid_exec();
        logic [30:0] w;
        in_valid = 1'b1;
        in_inst  = word_of(5);
        run      = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (inst[31] !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: exec got %b want 1", inst[31]); end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++;
        if (inst !== 32'h0) begin errors++; $display("FAIL rst_mid_inst: got %h want 0", inst); end
        checks++;
        if (busy !== 1'b0 || fifo_count !== 4'd0) begin errors++; $display("FAIL rst_mid_busy: busy %b count %0d want 0 0", busy, fifo_count); end
        tick();
        w        = word_of(9);
        in_valid = 1'b1;
        in_inst  = w;
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            checks++;
            if (inst[31] !== (k >= 2 && k <= 7)) begin errors++; $display("FAIL rst_fresh_exec c%0d: got %b", k, inst[31]); end
            checks++;
            if (done !== (k == 8)) begin errors++; $display("FAIL rst_fresh_done c%0d: got %b", k, done); end
            if (k >= 2) begin
                checks++;
                if (inst[30:0] !== w) begin errors++; $display("FAIL rst_fresh_fields c%0d: got %h want %h", k, inst[30:0], w); end
            end
            tick();
        end
        run = 1'b0;
    endtask

`ifdef DSP_SCHED_PERF_EN
    task automatic test_perf();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++;
        if (retired_cnt !== 32'd0 || busy_cnt !== 32'd0) begin errors++; $display("FAIL perf_reset: %0d %0d want 0 0", retired_cnt, busy_cnt); end
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_inst  = word_of(i + 80);
            tick();
        end
        in_valid = 1'b0;
        run = 1'b1;
        for (int c = 0; c < 35; c++) tick();
        checks++;
        if (retired_cnt !== 32'd4) begin errors++; $display("FAIL perf_retired: got %0d want 4", retired_cnt); end
        checks++;
        if (busy_cnt !== 32'd28) begin errors++; $display("FAIL perf_busy: got %0d want 28", busy_cnt); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        checks++;
        if (retired_cnt !== 32'd4 || busy_cnt !== 32'd28) begin errors++; $display("FAIL perf_flush: %0d %0d want 4 28", retired_cnt, busy_cnt); end
        run = 1'b0;
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_full_push_pop();
        test_flush();
        test_reset_mid_exec();
`ifdef DSP_SCHED_PERF_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
